// File: rtl/dijkstra_pkg.sv
// Shared definitions for the Dijkstra datapath.
//
// Contents:
//   - Default sizing for the distance store (node count, index width,
//     distance width, scan lanes).
//   - INFINITY: the all-ones distance that marks an unreached node.
//   - scan_state_e: state of the minimum-finding scan.
//   - cand_t: one min-search candidate (found flag, node index, distance)
//     at the default widths. Parameterised modules declare the same
//     layout locally at their own widths.
package dijkstra_pkg;

    localparam int DEFAULT_MAX_NODES   = 16;
    localparam int DEFAULT_INDEX_WIDTH = 4;
    localparam int DEFAULT_VALUE_WIDTH = 16;
    localparam int DEFAULT_LANES       = 4;

    localparam logic [DEFAULT_VALUE_WIDTH-1:0] INFINITY = '1;

    typedef enum logic [1:0] {
        SCAN  = 2'd0,
        VALID = 2'd1,
        EMPTY = 2'd2
    } scan_state_e;

    typedef struct packed {
        logic                           found;
        logic [DEFAULT_INDEX_WIDTH-1:0] index;
        logic [DEFAULT_VALUE_WIDTH-1:0] value;
    } cand_t;

endpackage

// File: rtl/min_reduce_lanes.sv
// Combinational minimum reduction over LANES entries plus two extra
// candidates (the running best and a same-cycle relax write).
//
// Ordering: a candidate wins when it is found and has a lower value, or
// an equal value and a lower index. Candidates that are not found never
// win over a found one.
//
// Ports:
//   lane_found_i  [LANES]              lane holds a usable entry
//   lane_index_i  [LANES][INDEX_WIDTH] node index of each lane
//   lane_value_i  [LANES][VALUE_WIDTH] distance of each lane
//   best_*_i                           running best candidate
//   relax_*_i                          relax candidate
//   min_*_o                            winner of all LANES+2 candidates
module min_reduce_lanes #(
    parameter int LANES       = 4,
    parameter int INDEX_WIDTH = 4,
    parameter int VALUE_WIDTH = 16
) (
    input  logic [LANES-1:0]                  lane_found_i,
    input  logic [LANES-1:0][INDEX_WIDTH-1:0] lane_index_i,
    input  logic [LANES-1:0][VALUE_WIDTH-1:0] lane_value_i,
    input  logic                              best_found_i,
    input  logic [INDEX_WIDTH-1:0]            best_index_i,
    input  logic [VALUE_WIDTH-1:0]            best_value_i,
    input  logic                              relax_found_i,
    input  logic [INDEX_WIDTH-1:0]            relax_index_i,
    input  logic [VALUE_WIDTH-1:0]            relax_value_i,
    output logic                              min_found_o,
    output logic [INDEX_WIDTH-1:0]            min_index_o,
    output logic [VALUE_WIDTH-1:0]            min_value_o
);

    localparam int LEAVES = LANES + 2;
    // Tree width rounded up to a power of two; padding leaves are "not found".
    localparam int TREE   = 1 << $clog2(LEAVES);

    typedef struct packed {
        logic                   found;
        logic [INDEX_WIDTH-1:0] index;
        logic [VALUE_WIDTH-1:0] value;
    } lane_cand_t;

    function automatic logic first_wins(input lane_cand_t a, input lane_cand_t b);
        return a.found && (!b.found || (a.value < b.value) ||
                           ((a.value == b.value) && (a.index <= b.index)));
    endfunction

    lane_cand_t leaf  [TREE];
    lane_cand_t level [TREE];

    for (genvar gi = 0; gi < TREE; gi++) begin : g_leaf
        if (gi < LANES) begin : g_lane
            assign leaf[gi] = {lane_found_i[gi], lane_index_i[gi], lane_value_i[gi]};
        end else if (gi == LANES) begin : g_best
            assign leaf[gi] = {best_found_i, best_index_i, best_value_i};
        end else if (gi == LANES + 1) begin : g_relax
            assign leaf[gi] = {relax_found_i, relax_index_i, relax_value_i};
        end else begin : g_pad
            assign leaf[gi] = '0;
        end
    end

    // In-place pairwise tree: at width w, slot i takes the winner of slots
    // 2i and 2i+1. Slots >= i are still untouched at this width, so the
    // reads always see the previous level.
    always_comb begin
        for (int i = 0; i < TREE; i++) begin
            level[i] = leaf[i];
        end
        for (int w = TREE / 2; w >= 1; w = w / 2) begin
            for (int i = 0; i < w; i++) begin
                level[i] = first_wins(level[2*i], level[2*i+1]) ? level[2*i] : level[2*i+1];
            end
        end
    end

    assign min_found_o = level[0].found;
    assign min_index_o = level[0].index;
    assign min_value_o = level[0].value;

endmodule

// File: rtl/relax_priority_queue.sv
// Distance store and minimum-finding priority queue for the Dijkstra
// datapath.
//
// Holds one tentative distance per node plus a visited mask. Relax writes
// lower a distance when the candidate is strictly smaller and the node is
// unvisited. The minimum unvisited node is located by a scan that covers
// LANES entries per cycle (MAX_NODES/LANES cycles per scan); once found it
// is held and kept current against later relax writes without rescanning.
//
// Ports:
//   clock, reset      clock; synchronous active-high reset
//   src_index         source node, given distance 0 while reset is high
//   relax_en/_index/_value   relax request
//   relax_updated     registered: previous cycle's relax was written
//   read_index/read_value    combinational distance read
//   min_valid/min_index/min_value   current minimum unvisited node
//   pop               mark the current minimum visited and rescan
//   empty             no unvisited node with a finite distance
module relax_priority_queue
    import dijkstra_pkg::*;
#(
    parameter int MAX_NODES   = DEFAULT_MAX_NODES,
    parameter int INDEX_WIDTH = DEFAULT_INDEX_WIDTH,
    parameter int VALUE_WIDTH = DEFAULT_VALUE_WIDTH,
    parameter int LANES       = DEFAULT_LANES
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [INDEX_WIDTH-1:0] src_index,
    input  logic                   relax_en,
    input  logic [INDEX_WIDTH-1:0] relax_index,
    input  logic [VALUE_WIDTH-1:0] relax_value,
    output logic                   relax_updated,
    input  logic [INDEX_WIDTH-1:0] read_index,
    output logic [VALUE_WIDTH-1:0] read_value,
    output logic                   min_valid,
    output logic [INDEX_WIDTH-1:0] min_index,
    output logic [VALUE_WIDTH-1:0] min_value,
    input  logic                   pop,
    output logic                   empty
);

    localparam int GROUPS = MAX_NODES / LANES;
    localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [GW-1:0]          LAST_GROUP = GW'(GROUPS - 1);
    localparam logic [VALUE_WIDTH-1:0] INF        = '1;
    localparam logic [INDEX_WIDTH:0]   NODE_LIMIT = (INDEX_WIDTH + 1)'(MAX_NODES);

    typedef struct packed {
        logic                   found;
        logic [INDEX_WIDTH-1:0] index;
        logic [VALUE_WIDTH-1:0] value;
    } node_cand_t;

    function automatic logic orders_before(input node_cand_t a, input node_cand_t b);
        return a.found && (!b.found || (a.value < b.value) ||
                           ((a.value == b.value) && (a.index < b.index)));
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [VALUE_WIDTH-1:0] dist_q [MAX_NODES];
    logic [MAX_NODES-1:0]   visited_q;
    scan_state_e            state_q, state_d;
    logic [GW-1:0]          group_q, group_d;
    node_cand_t             best_q, best_d;
    logic                   relax_updated_q;

    // ------------------------------------------------------------------
    // Relax qualification
    // ------------------------------------------------------------------
    logic       relax_in_range;
    logic       read_in_range;
    logic       pop_fire;
    logic       relax_hits_min;
    logic       relax_ok;
    node_cand_t relax_cand;

    assign relax_in_range = {1'b0, relax_index} < NODE_LIMIT;
    assign read_in_range  = {1'b0, read_index} < NODE_LIMIT;
    assign pop_fire       = pop && (state_q == VALID);
    // The node being popped becomes visited on this edge, so a relax aimed
    // at it in the same cycle must not land.
    assign relax_hits_min = pop_fire && (relax_index == best_q.index);
    // An INFINITY candidate can never be strictly below a stored distance.
    assign relax_ok       = relax_en && relax_in_range && !relax_hits_min &&
                            !visited_q[relax_index] &&
                            (relax_value < dist_q[relax_index]);
    assign relax_cand     = {relax_ok, relax_index, relax_value};

    // ------------------------------------------------------------------
    // Scan lanes: group group_q, visited and unreached entries masked out
    // ------------------------------------------------------------------
    logic [LANES-1:0]                  lane_found;
    logic [LANES-1:0][INDEX_WIDTH-1:0] lane_index;
    logic [LANES-1:0][VALUE_WIDTH-1:0] lane_value;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [INDEX_WIDTH-1:0] lane_addr;
        assign lane_addr      = INDEX_WIDTH'(int'(group_q) * LANES + gi);
        assign lane_found[gi] = !visited_q[lane_addr] && (dist_q[lane_addr] != INF);
        assign lane_index[gi] = lane_addr;
        assign lane_value[gi] = dist_q[lane_addr];
    end

    logic                   scan_found;
    logic [INDEX_WIDTH-1:0] scan_index;
    logic [VALUE_WIDTH-1:0] scan_value;
    node_cand_t             scan_best;

    min_reduce_lanes #(
        .LANES       (LANES),
        .INDEX_WIDTH (INDEX_WIDTH),
        .VALUE_WIDTH (VALUE_WIDTH)
    ) u_reduce (
        .lane_found_i  (lane_found),
        .lane_index_i  (lane_index),
        .lane_value_i  (lane_value),
        .best_found_i  (best_q.found),
        .best_index_i  (best_q.index),
        .best_value_i  (best_q.value),
        .relax_found_i (relax_cand.found),
        .relax_index_i (relax_cand.index),
        .relax_value_i (relax_cand.value),
        .min_found_o   (scan_found),
        .min_index_o   (scan_index),
        .min_value_o   (scan_value)
    );

    assign scan_best = {scan_found, scan_index, scan_value};

    // ------------------------------------------------------------------
    // Scan state machine: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        group_d = group_q;
        best_d  = best_q;
        case (state_q)
            SCAN: begin
                best_d = scan_best;
                if (group_q == LAST_GROUP) begin
                    group_d = '0;
                    state_d = scan_best.found ? VALID : EMPTY;
                end else begin
                    group_d = group_q + 1'b1;
                end
            end
            VALID: begin
                if (pop_fire) begin
                    state_d = SCAN;
                    group_d = '0;
                    best_d  = '0;
                end else if (orders_before(relax_cand, best_q)) begin
                    // Distances only decrease, so a lower-ordering relax is
                    // always the new minimum, even when it targets best_q.
                    best_d = relax_cand;
                end
            end
            EMPTY: begin
                if (relax_ok) begin
                    state_d = SCAN;
                    group_d = '0;
                    best_d  = '0;
                end
            end
            default: begin
                state_d = SCAN;
                group_d = '0;
                best_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= SCAN;
            group_q         <= '0;
            best_q          <= '0;
            relax_updated_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            group_q         <= group_d;
            best_q          <= best_d;
            relax_updated_q <= relax_ok;
        end
    end

    // ------------------------------------------------------------------
    // Distance store and visited mask
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < MAX_NODES; i++) begin
                dist_q[i] <= (INDEX_WIDTH'(i) == src_index) ? '0 : INF;
            end
            visited_q <= '0;
        end else begin
            if (relax_ok) begin
                dist_q[relax_index] <= relax_value;
            end
            if (pop_fire) begin
                visited_q[best_q.index] <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign relax_updated = relax_updated_q;
    assign read_value    = read_in_range ? dist_q[read_index] : INF;
    assign min_valid     = (state_q == VALID);
    assign empty         = (state_q == EMPTY);
    assign min_index     = (state_q == VALID) ? best_q.index : '0;
    assign min_value     = (state_q == VALID) ? best_q.value : '0;

endmodule

// File: tb/tb_relax_priority_queue.sv
module tb_relax_priority_queue;
    import dijkstra_pkg::*;

    localparam int N    = 16;
    localparam int IW   = 4;
    localparam int VW   = 16;
    localparam int NDUT = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [IW-1:0] src_index   = '0;
    logic          relax_en    = 1'b0;
    logic [IW-1:0] relax_index = '0;
    logic [VW-1:0] relax_value = '0;
    logic [IW-1:0] read_index  = '0;
    logic          pop         = 1'b0;

    logic          ru   [NDUT];
    logic [VW-1:0] rv   [NDUT];
    logic          mv   [NDUT];
    logic [IW-1:0] mi   [NDUT];
    logic [VW-1:0] mval [NDUT];
    logic          em   [NDUT];

    always #5 clock = ~clock;

    // Three instances sharing every input: LANES = 4, 16, 1.
    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        relax_priority_queue #(
            .MAX_NODES   (N),
            .INDEX_WIDTH (IW),
            .VALUE_WIDTH (VW),
            .LANES       (gi == 0 ? 4 : (gi == 1 ? 16 : 1))
        ) u_dut (
            .clock         (clock),
            .reset         (reset),
            .src_index     (src_index),
            .relax_en      (relax_en),
            .relax_index   (relax_index),
            .relax_value   (relax_value),
            .relax_updated (ru[gi]),
            .read_index    (read_index),
            .read_value    (rv[gi]),
            .min_valid     (mv[gi]),
            .min_index     (mi[gi]),
            .min_value     (mval[gi]),
            .pop           (pop),
            .empty         (em[gi])
        );
    end

    int compared   = 0;
    int mismatched = 0;

    // Reference model and scoreboards
    logic [VW-1:0] m_dist [N];
    logic          m_vis  [N];
    logic          exp_upd_q [$];
    cand_t         exp_min_q [$];

    function automatic int groups_of(input int d);
        return (d == 0) ? 4 : ((d == 1) ? 1 : 16);
    endfunction

    function automatic cand_t m_min();
        cand_t c;
        c = '0;
        for (int i = 0; i < N; i++) begin
            if (!m_vis[i] && m_dist[i] != INFINITY && (!c.found || m_dist[i] < c.value)) begin
                c = {1'b1, IW'(i), m_dist[i]};
            end
        end
        return c;
    endfunction

    task automatic m_init(input logic [IW-1:0] src);
        for (int i = 0; i < N; i++) begin
            m_dist[i] = (IW'(i) == src) ? '0 : INFINITY;
            m_vis[i]  = 1'b0;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic all_settled();
        logic s;
        s = 1'b1;
        for (int d = 0; d < NDUT; d++) s = s && (mv[d] || em[d]);
        return s;
    endfunction

    task automatic check_read(input string tag, input logic [IW-1:0] idx, input logic [VW-1:0] expv);
        read_index = idx;
        #1;
        for (int d = 0; d < NDUT; d++) check($sformatf("%s_d%0d", tag, d), rv[d], expv);
    endtask

    // Reset, check reset outputs, then count cycles until min_valid.
    task automatic reset_and_count(input string tag, input logic [IW-1:0] src);
        reset = 1'b1; src_index = src; relax_en = 1'b0; pop = 1'b0;
        step();
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("%s_rst_valid_d%0d", tag, d), mv[d], 0);
            check($sformatf("%s_rst_empty_d%0d", tag, d), em[d], 0);
            check($sformatf("%s_rst_upd_d%0d", tag, d), ru[d], 0);
            check($sformatf("%s_rst_minout_d%0d", tag, d), {mi[d], mval[d]}, 0);
        end
        m_init(src);
        reset = 1'b0;
        for (int n = 1; n <= 16; n++) begin
            step();
            for (int d = 0; d < NDUT; d++)
                check($sformatf("%s_latency_c%0d_d%0d", tag, n, d), mv[d], (n >= groups_of(d)) ? 1 : 0);
        end
        $display("reset src=%0d: latency checked", src);
    endtask

    task automatic do_relax(input string tag, input logic [IW-1:0] idx, input logic [VW-1:0] val);
        logic ok;
        logic e;
        ok = !m_vis[idx] && (val < m_dist[idx]);
        if (ok) m_dist[idx] = val;
        exp_upd_q.push_back(ok);
        relax_en = 1'b1; relax_index = idx; relax_value = val;
        step();
        relax_en = 1'b0;
        e = exp_upd_q.pop_front();
        for (int d = 0; d < NDUT; d++) check($sformatf("%s_upd_d%0d", tag, d), ru[d], e);
        $display("relax node=%0d value=%0d expect_written=%0d", idx, val, e);
    endtask

    task automatic do_pop(input string tag);
        cand_t mc;
        mc = m_min();
        if (mc.found) m_vis[mc.index] = 1'b1;
        pop = 1'b1;
        step();
        pop = 1'b0;
        for (int d = 0; d < NDUT; d++) check($sformatf("%s_popdrop_d%0d", tag, d), mv[d], 0);
        $display("pop node=%0d", mc.index);
    endtask

    task automatic settle_and_check(input string tag);
        cand_t e;
        exp_min_q.push_back(m_min());
        for (int i = 0; i < 40 && !all_settled(); i++) step();
        check($sformatf("%s_settled", tag), all_settled(), 1);
        e = exp_min_q.pop_front();
        for (int d = 0; d < NDUT; d++) begin
            if (e.found) begin
                check($sformatf("%s_valid_d%0d", tag, d), mv[d], 1);
                check($sformatf("%s_index_d%0d", tag, d), mi[d], e.index);
                check($sformatf("%s_value_d%0d", tag, d), mval[d], e.value);
            end else begin
                check($sformatf("%s_empty_d%0d", tag, d), em[d], 1);
            end
        end
        $display("min expect found=%0d node=%0d value=%0d", e.found, e.index, e.value);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic e;
        // 1: reset with source 5, latency and first minimum
        reset_and_count("t1", 4'd5);
        settle_and_check("t1_min");
        for (int d = 0; d < NDUT; d++) check($sformatf("t1_notempty_d%0d", d), em[d], 0);
        check_read("t1_read_src", 4'd5, '0);
        check_read("t1_read_inf", 4'd2, INFINITY);

        // 2: pop the only finite node -> empty after G cycles; relax of visited node ignored
        do_pop("t2");
        for (int k = 1; k <= 16; k++) begin
            step();
            for (int d = 0; d < NDUT; d++)
                check($sformatf("t2_empty_c%0d_d%0d", k, d), em[d], (k >= groups_of(d)) ? 1 : 0);
        end
        do_relax("t2_visited", 4'd5, 16'd3);
        for (int d = 0; d < NDUT; d++) check($sformatf("t2_stay_empty_d%0d", d), em[d], 1);
        check_read("t2_read5", 4'd5, '0);

        // 3: relaxes during the scan, tie broken to the lower index
        reset_and_count("t3", 4'd5);
        settle_and_check("t3_start");
        do_pop("t3");
        do_relax("t3_r7", 4'd7, 16'd10);
        do_relax("t3_r3", 4'd3, 16'd10);
        settle_and_check("t3_tie");
        do_relax("t3_r3_up", 4'd3, 16'd12);
        check_read("t3_read3", 4'd3, 16'd10);

        // 4: decrease-key in VALID without a drop, then pop with relax to the min node
        do_relax("t4_r9", 4'd9, 16'd4);
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("t4_keep_valid_d%0d", d), mv[d], 1);
            check($sformatf("t4_new_index_d%0d", d), mi[d], 9);
            check($sformatf("t4_new_value_d%0d", d), mval[d], 4);
        end
        m_vis[9] = 1'b1;
        exp_upd_q.push_back(1'b0);
        pop = 1'b1; relax_en = 1'b1; relax_index = 4'd9; relax_value = 16'd1;
        step();
        pop = 1'b0; relax_en = 1'b0;
        e = exp_upd_q.pop_front();
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("t4_drop_upd_d%0d", d), ru[d], e);
            check($sformatf("t4_drop_valid_d%0d", d), mv[d], 0);
        end
        $display("pop+relax node=9 value=1 expect_written=0");
        check_read("t4_read9", 4'd9, 16'd4);
        settle_and_check("t4_after");
        do_relax("t4_r9_visited", 4'd9, 16'd0);

        // 5: reset two cycles into a scan restarts everything
        do_pop("t5");
        step();
        step();
        reset_and_count("t5", 4'd11);
        settle_and_check("t5_min");

        // 6: random relax/pop stream, all lane widths against the model
        for (int it = 0; it < 30; it++) begin
            int nrel;
            nrel = $urandom_range(3, 1);
            for (int r = 0; r < nrel; r++) begin
                logic [IW-1:0] idx;
                logic [VW-1:0] val;
                idx = IW'($urandom_range(N - 1, 0));
                val = ($urandom_range(7, 0) == 0) ? INFINITY : VW'($urandom_range(300, 0));
                do_relax($sformatf("t6_i%0d_r%0d", it, r), idx, val);
            end
            settle_and_check($sformatf("t6_i%0d", it));
            if (m_min().found && all_settled()) do_pop($sformatf("t6_i%0d", it));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
